// File: rtl/tc_bit_collector_if.sv
// tc_bit_collector_if: bit-in / word-out handshake bundle
// for the serial-to-parallel collector.
interface tc_bit_collector_if #(
  parameter int WIDTH = 8
);
  localparam int FW = $clog2(WIDTH + 1);

  logic             save;
  logic             in;
  logic             flush;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic [FW-1:0]    fill;
  logic             busy;
  logic             overflow;

  modport master (
    output save, in, flush, out_ready,
    input  out, out_valid, fill, busy, overflow
  );

  modport slave (
    input  save, in, flush, out_ready,
    output out, out_valid, fill, busy, overflow
  );
endinterface

// File: rtl/tc_bit_collector.sv
// tc_bit_collector: packs strobed bits into WIDTH-bit words
// with one word of output buffering behind valid/ready.
module tc_bit_collector #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  tc_bit_collector_if.slave bus
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] WFULL = FW'(WIDTH);
  localparam logic [FW-1:0] WTOP  = FW'(WIDTH - 1);

  logic [WIDTH-1:0] asm_q, asm_a, asm_n;
  logic [WIDTH-1:0] out_q, out_n, bitm;
  logic [FW-1:0]    fill_q, fill_a, fill_n, pos;
  logic             valid_q, valid_n;
  logic             busy_q, busy_n;
  logic             ovf_q, ovf_n;
  logic             accept, done, xfer;

  always_comb begin
    accept = bus.save & ~busy_q;
    pos    = MSB_FIRST ? (WTOP - fill_q) : fill_q;
    bitm   = WIDTH'(accept & bus.in) << pos;
    asm_a  = asm_q | bitm;
    fill_a = fill_q + FW'(accept);
    // a held word counts as complete until it can move
    done   = busy_q
           | (fill_a == WFULL)
           | (bus.flush & (fill_a != '0));
    xfer   = done & (~valid_q | bus.out_ready);

    asm_n   = asm_a;
    fill_n  = fill_a;
    out_n   = out_q;
    valid_n = valid_q & ~bus.out_ready;
    busy_n  = 1'b0;
    ovf_n   = ovf_q | (bus.save & busy_q);

    if (xfer) begin
      out_n   = asm_a;
      valid_n = 1'b1;
      asm_n   = '0;
      fill_n  = '0;
    end else if (done) begin
      busy_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      asm_q   <= '0;
      fill_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      asm_q   <= asm_n;
      fill_q  <= fill_n;
      out_q   <= out_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      ovf_q   <= ovf_n;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.fill      = fill_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_tc_bit_collector.sv
// tb_tc_bit_collector: drives LSB- and MSB-first collectors
// with one stimulus and checks both against a queue model.
module tb_tc_bit_collector;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic save = 1'b0;
  logic din = 1'b0;
  logic flush = 1'b0;
  logic ready = 1'b0;

  always #5 clk = ~clk;

  tc_bit_collector_if #(.WIDTH(8)) b0 ();
  tc_bit_collector_if #(.WIDTH(8)) b1 ();

  assign b0.save      = save;
  assign b0.in        = din;
  assign b0.flush     = flush;
  assign b0.out_ready = ready;
  assign b1.save      = save;
  assign b1.in        = din;
  assign b1.flush     = flush;
  assign b1.out_ready = ready;

  tc_bit_collector #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  tc_bit_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  int nchk = 0;
  int nerr = 0;

  // reference: pending bits as a queue, one output slot
  bit         cur[$];
  logic       mv = 1'b0;
  logic       mbusy = 1'b0;
  logic       movf = 1'b0;
  logic [7:0] mw0 = 8'h00;
  logic [7:0] mw1 = 8'h00;

  function automatic logic [7:0] pack(input bit msb);
    logic [7:0] w;
    w = 8'h00;
    foreach (cur[i]) begin
      if (msb) w[7-i] = cur[i];
      else     w[i]   = cur[i];
    end
    return w;
  endfunction

  task automatic model_step();
    if (!rst) begin
      cur.delete();
      mv = 0; mbusy = 0; movf = 0;
      mw0 = 8'h00; mw1 = 8'h00;
    end else if (mbusy) begin
      if (save) movf = 1;
      if (ready) begin
        mw0 = pack(0); mw1 = pack(1);
        cur.delete();
        mbusy = 0; mv = 1;
      end
    end else begin
      if (save) cur.push_back(din);
      if (cur.size() == 8 || (flush && cur.size() > 0)) begin
        if (!mv || ready) begin
          mw0 = pack(0); mw1 = pack(1);
          cur.delete();
          mv = 1;
        end else begin
          mbusy = 1;
        end
      end else if (mv && ready) begin
        mv = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [14:0] got(input int k);
    if (k == 0)
      return {b0.out, b0.out_valid, b0.fill, b0.busy, b0.overflow};
    return {b1.out, b1.out_valid, b1.fill, b1.busy, b1.overflow};
  endfunction

  function automatic logic [14:0] want(input int k);
    logic [3:0] f;
    f = 4'(cur.size());
    return {(k == 0) ? mw0 : mw1, mv, f, mbusy, movf};
  endfunction

  task automatic test_reset();
    rst = 0; save = 1; din = 1; flush = 1; ready = 1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      nchk++;
      if (got(k) !== 15'h0) begin
        nerr++;
        $display("FAIL reset dut%0d got=%h want=%h", k, got(k), 15'h0);
      end
    end
    rst = 1; save = 0; din = 0; flush = 0;
  endtask

  task automatic test_pack();
    bit b[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    ready = 1;
    for (int i = 0; i < 8; i++) begin
      save = 1; din = b[i];
      tick();
      if (i < 7) begin
        nchk++;
        if (b0.out_valid !== 1'b0) begin
          nerr++;
          $display("FAIL pack_early bit%0d got=%b want=0", i, b0.out_valid);
        end
      end
    end
    nchk++;
    if (b0.out !== 8'h4D || b0.out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL pack_lsb got=%h/%b want=4d/1", b0.out, b0.out_valid);
    end
    nchk++;
    if (b1.out !== 8'hB2 || b1.out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL pack_msb got=%h/%b want=b2/1", b1.out, b1.out_valid);
    end
    save = 0;
    tick();
    nchk++;
    if (b0.out_valid !== 1'b0 || b1.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL pack_oneshot got=%b%b want=00", b0.out_valid, b1.out_valid);
    end
  endtask

  task automatic test_flush();
    ready = 1;
    for (int i = 0; i < 3; i++) begin
      save = 1; din = 1;
      tick();
    end
    save = 0; flush = 1;
    tick();
    nchk++;
    if (b0.out !== 8'h07 || b0.out_valid !== 1'b1 || b0.fill !== 4'd0) begin
      nerr++;
      $display("FAIL flush_lsb got=%h/%b/%0d want=07/1/0", b0.out, b0.out_valid, b0.fill);
    end
    nchk++;
    if (b1.out !== 8'hE0 || b1.out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL flush_msb got=%h/%b want=e0/1", b1.out, b1.out_valid);
    end
    flush = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
    nchk++;
    if (b0.out_valid !== 1'b0 || b0.fill !== 4'd0) begin
      nerr++;
      $display("FAIL flush_empty got=%b/%0d want=0/0", b0.out_valid, b0.fill);
    end
  endtask

  task automatic test_backpressure();
    ready = 0;
    for (int i = 0; i < 17; i++) begin
      save = 1; din = (i < 8 || i == 16);
      tick();
      if (i == 15) begin
        nchk++;
        if (b0.out !== 8'hFF || b0.busy !== 1'b1 ||
            b0.fill !== 4'd8 || b0.overflow !== 1'b0) begin
          nerr++;
          $display("FAIL bp_busy got=%h/%b/%0d/%b want=ff/1/8/0",
                   b0.out, b0.busy, b0.fill, b0.overflow);
        end
      end
    end
    save = 0;
    nchk++;
    if (b0.overflow !== 1'b1 || b0.fill !== 4'd8 || b1.overflow !== 1'b1) begin
      nerr++;
      $display("FAIL bp_ovf got=%b/%0d/%b want=1/8/1",
               b0.overflow, b0.fill, b1.overflow);
    end
    ready = 1;
    tick();
    nchk++;
    if (b0.out !== 8'h00 || b0.out_valid !== 1'b1 || b0.busy !== 1'b0) begin
      nerr++;
      $display("FAIL bp_drain1 got=%h/%b/%b want=00/1/0",
               b0.out, b0.out_valid, b0.busy);
    end
    tick();
    nchk++;
    if (b0.out_valid !== 1'b0 || b0.overflow !== 1'b1 || b1.busy !== 1'b0) begin
      nerr++;
      $display("FAIL bp_drain2 got=%b/%b/%b want=0/1/0",
               b0.out_valid, b0.overflow, b1.busy);
    end
    for (int k = 0; k < 2; k++) begin
      nchk++;
      if (got(k) !== want(k)) begin
        nerr++;
        $display("FAIL bp_model dut%0d got=%h want=%h", k, got(k), want(k));
      end
    end
  endtask

  task automatic test_stream();
    bit bits[64];
    int words = 0;
    logic [7:0] w;
    rst = 0;
    tick();
    rst = 1; ready = 1;
    for (int i = 0; i < 64; i++) bits[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 64; i++) begin
      save = 1; din = bits[i];
      tick();
      nchk++;
      if (b0.out_valid !== ((i % 8) == 7)) begin
        nerr++;
        $display("FAIL stream_valid bit%0d got=%b", i, b0.out_valid);
      end
      if ((i % 8) == 7) begin
        words++;
        w = 8'h00;
        for (int j = 0; j < 8; j++) w[j] = bits[i - 7 + j];
        nchk++;
        if (b0.out !== w) begin
          nerr++;
          $display("FAIL stream_word%0d got=%h want=%h", words, b0.out, w);
        end
        nchk++;
        if (got(1) !== want(1)) begin
          nerr++;
          $display("FAIL stream_msb%0d got=%h want=%h", words, got(1), want(1));
        end
      end
    end
    save = 0;
    nchk++;
    if (words != 8 || b0.overflow !== 1'b0) begin
      nerr++;
      $display("FAIL stream_count got=%0d/%b want=8/0", words, b0.overflow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      save  = 1'($urandom_range(0, 1));
      din   = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 9) == 0);
      ready = ($urandom_range(0, 2) != 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        nchk++;
        if (got(k) !== want(k)) begin
          nerr++;
          $display("FAIL random cyc%0d dut%0d got=%h want=%h",
                   i, k, got(k), want(k));
        end
      end
    end
    save = 0; flush = 0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] a5;
    a5 = 8'hA5;
    ready = 1;
    rst = 0;
    tick();
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      save = 1; din = 1;
      tick();
    end
    save = 0; rst = 0;
    tick();
    rst = 1;
    for (int i = 0; i < 8; i++) begin
      save = 1; din = a5[i];
      tick();
    end
    save = 0;
    nchk++;
    if (b0.out !== 8'hA5 || b0.out_valid !== 1'b1 || b0.fill !== 4'd0) begin
      nerr++;
      $display("FAIL reset_mid_lsb got=%h/%b/%0d want=a5/1/0",
               b0.out, b0.out_valid, b0.fill);
    end
    nchk++;
    if (b1.out !== 8'hA5 || b1.out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL reset_mid_msb got=%h/%b want=a5/1", b1.out, b1.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_flush();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
